// File: rtl/fp_ci_sequencer.sv
// Custom-instruction sequencer for the shared FP sub/mult pipeline: runs one
// instruction at a time, gates the pipeline enable for its latency, captures results.
module fp_ci_sequencer #(
  parameter int SUB_LAT  = 7,
  parameter int MULT_LAT = 5
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        dp_aclr,
  output logic        dp_clk_en,
  output logic [7:0]  dp_n,
  output logic [31:0] dp_dataa,
  output logic [31:0] dp_datab,
  input  logic [31:0] dp_result
);

  localparam int MAX_LAT = (SUB_LAT > MULT_LAT) ? SUB_LAT : MULT_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] SUB_LAST  = CW'(SUB_LAT - 1);
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_LAT - 1);

  localparam logic [7:0] OP_SUB   = 8'd0;
  localparam logic [7:0] OP_MULT  = 8'd1;
  localparam logic [7:0] OP_MSUB  = 8'd2;
  localparam logic [7:0] OP_LOADC = 8'd3;

  typedef enum logic [2:0] {IDLE, RUN1, CAP1, RUN2, CAP2, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    op;
  logic [31:0]   c_reg;
  logic          run;
  logic [CW-1:0] last;

  assign dp_aclr   = ~aclr_n;
  // The pipeline only advances on enabled cycles of a RUN state.
  assign dp_clk_en = run & clk_en;
  // RUN2 always issues a subtract, so dp_n selects the latency for both passes.
  assign last      = (dp_n == OP_SUB) ? SUB_LAST : MULT_LAST;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= 8'd0;
      c_reg    <= 32'd0;
      run      <= 1'b0;
      result   <= 32'd0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      dp_n     <= 8'd0;
      dp_dataa <= 32'd0;
      dp_datab <= 32'd0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (start) begin
            op   <= n;
            err  <= 1'b0;
            busy <= 1'b1;
            case (n)
              OP_SUB, OP_MULT, OP_MSUB: begin
                dp_n     <= (n == OP_SUB) ? 8'd0 : 8'd1;
                dp_dataa <= dataa;
                dp_datab <= datab;
                run      <= 1'b1;
                state    <= RUN1;
              end
              OP_LOADC: begin
                c_reg  <= dataa;
                result <= dataa;
                done   <= 1'b1;
                state  <= DONE;
              end
              default: begin
                result <= 32'd0;
                err    <= 1'b1;
                done   <= 1'b1;
                state  <= DONE;
              end
            endcase
          end
        end
        RUN1, RUN2: begin
          if (cnt == last) begin
            cnt   <= '0;
            run   <= 1'b0;
            state <= (state == RUN1) ? CAP1 : CAP2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAP1: begin
          if (op == OP_MSUB) begin
            // Product P goes straight back in as the minuend of the second pass.
            dp_n     <= 8'd0;
            dp_dataa <= dp_result;
            dp_datab <= c_reg;
            run      <= 1'b1;
            state    <= RUN2;
          end else begin
            result <= dp_result;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        CAP2: begin
          result <= dp_result;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_ci_sequencer.md
# fp_ci_sequencer

Multi-cycle Nios II custom-instruction sequencer for the shared FP sub/mult datapath (opcode 0 = subtract, opcode 1 = multiply, fixed pipeline latencies).
- Accepts one instruction at a time on a start/done handshake and registers its operands.
- Drives the datapath's clock-enable for exactly the pipeline latency, then captures the result.
- Adds a two-pass fused multiply-subtract (a*b − c) using a stored C register.
- Sits between the custom-instruction slave port and the FP datapath.

## Interface
- SUB_LAT, 7, subtract pipeline latency in enabled clocks (≥1)
- MULT_LAT, 5, multiply pipeline latency in enabled clocks (≥1)
- clock  in  1  system clock, rising edge
- aclr_n  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; when low, all state, counters and outputs hold
- start  in  1  instruction request, sampled only in IDLE
- n  in  8  opcode: 0 SUB, 1 MULT, 2 MSUB, 3 LOADC, others illegal
- dataa  in  32  operand A (IEEE-754 single)
- datab  in  32  operand B
- result  out  32  registered result, valid when done=1, held afterwards
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every non-IDLE state
- err  out  1  high with done for an illegal opcode; cleared at next accepted start
- dp_aclr  out  1  datapath clear, = ~aclr_n
- dp_clk_en  out  1  datapath pipeline enable
- dp_n  out  8  datapath opcode (0 sub, 1 mult)
- dp_dataa, dp_datab  out  32 each  datapath operands, registered, stable for a whole pass
- dp_result  in  32  datapath result

## Operation
- States: IDLE, RUN1, CAP1, RUN2, CAP2, DONE.
- IDLE: start=1 with clk_en=1 latches dataa/datab/n. Next state:
  - SUB/MULT/MSUB → RUN1.
  - LOADC → DONE; C ← dataa, result ← dataa.
  - Illegal → DONE; result ← 0, err ← 1.
- RUN1 drives the datapath operation:
  - SUB: dp_n=0, (A,B).
  - MULT: dp_n=1, (A,B).
  - MSUB: dp_n=1, (A,B).
- RUN1 operation:
  - dp_clk_en=clk_en; cnt counts enabled cycles 0..L−1.
  - L = SUB_LAT if dp_n=0, else MULT_LAT.
  - cnt=L−1 with clk_en=1 → CAP1.
- CAP1:
  - dp_clk_en=0 (pipeline frozen); dp_result is sampled.
  - SUB/MULT: result ← dp_result → DONE.
  - MSUB: P ← dp_result → RUN2.
- RUN2: dp_n=0, operands (P, C), L=SUB_LAT → CAP2.
- CAP2: result ← dp_result → DONE.
- DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored; there is no queue.
- Stale pipeline contents need no flush; L enabled clocks fully refill the pipeline.
- C register: reset value 0, persists across instructions, written only by LOADC.
- No arithmetic is done in this block. NaN/Inf/denormal handling belongs to the datapath.

## Timing
- Reset (aclr_n=0, immediate): state IDLE; result=0, done=0, busy=0, err=0, dp_clk_en=0, dp_n=0, dp_dataa=dp_datab=0, C=0, P=0, cnt=0.
- Reset mid-operation aborts without a done pulse.
- Cycle 0 is the cycle where start is sampled. With clk_en held high, done is in cycle:
  - SUB: SUB_LAT+2 (9 by default).
  - MULT: MULT_LAT+2 (7 by default).
  - MSUB: MULT_LAT+SUB_LAT+3 (15 by default).
  - LOADC, illegal: cycle 1.
- busy is high from cycle 1 through the done cycle inclusive. start is accepted again in the cycle after done.
- Each clk_en=0 cycle after acceptance delays done by exactly one cycle. dp_clk_en is 0 in those cycles.
- dp_clk_en is never 1 in IDLE, CAP1, CAP2 or DONE.

## Test plan
- SUB: dataa=0x40400000 (3.0), datab=0x3F800000 (1.0), n=0 → done in cycle 9, result=0x40000000, err=0; busy cycles 1–9.
- MULT: 2.0×3.0 (0x40000000, 0x40C00000 expected) → done in cycle 7, result=0x40C00000; dp_clk_en high for exactly 5 cycles.
- LOADC dataa=0x3FC00000 (1.5), done cycle 1. Then MSUB dataa=0x40000000, datab=0x40400000 → done in cycle 15, result=0x40900000 (4.5).
- Illegal n=0x07 → done cycle 1, result=0, err=1. Next SUB is accepted and err=0.
- MSUB with clk_en low for cycles 4–6 and start re-asserted while busy → done in cycle 18; extra start ignored; result correct.
- aclr_n low at cycle 6 of an MSUB → all outputs 0 immediately, no done. A following MULT 2.0×3.0 completes normally and C=0.
